// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the MIPS32 core.
// Merges ID/EX/MEM stall requests into the 6-bit stall vector, sequences
// exception entry and ERET (flush + new_pc), holds a pending exception
// during a MEM bus stall, and runs a sticky stall watchdog.
// Optional feature macro: PIPE_PERF_CNT_EN adds stall-cycle and flush counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter int          MAX_STALL  = 16,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  input  logic        i_stallreq_mem,
  input  logic        i_excp_valid,
  input  logic        i_excp_eret,
  input  logic [31:0] i_epc_in,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] o_perf_stall_cycles,
  output logic [31:0] o_perf_flush_count,
`endif
  output logic        o_stall_timeout
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0]       STALL_NONE = 6'b000000;
  localparam logic [5:0]       STALL_ID   = 6'b000111;
  localparam logic [5:0]       STALL_EX   = 6'b001111;
  localparam logic [5:0]       STALL_MEM  = 6'b011111;
  localparam logic [5:0]       STALL_ALL  = 6'b111111;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_STALL);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_target;
  logic [31:0]       r_new_pc;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  w_stall_cnt_nxt;
  logic              r_timeout;
  logic [5:0]        w_stall;
  logic              w_flush;
  logic              w_load_target;
  logic              w_load_pc;
  logic [31:0]       w_pc_src;
  logic [31:0]       w_excp_target;

  assign w_excp_target = i_excp_eret ? i_epc_in : EXC_VECTOR;

  // Next-state, stall vector and redirect control for the exception sequencer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_state_nxt   = r_state;
    w_stall       = STALL_NONE;
    w_flush       = 1'b0;
    w_load_target = 1'b0;
    w_load_pc     = 1'b0;
    w_pc_src      = r_target;
    case (r_state)
      ST_RUN: begin
        if (i_excp_valid) begin
          if (i_stallreq_mem) begin
            // Bus still busy: remember the target and wait in PEND.
            w_stall       = STALL_MEM;
            w_load_target = 1'b1;
            w_state_nxt   = ST_PEND;
          end else begin
            w_stall     = STALL_ALL;
            w_load_pc   = 1'b1;
            w_pc_src    = w_excp_target;
            w_state_nxt = ST_FLUSH;
          end
        end else if (i_stallreq_mem) begin
          w_stall = STALL_MEM;
        end else if (i_stallreq_ex) begin
          w_stall = STALL_EX;
        end else if (i_stallreq_id) begin
          w_stall = STALL_ID;
        end
      end
      ST_PEND: begin
        // First exception wins; later excp_valid pulses are not looked at.
        if (i_stallreq_mem) begin
          w_stall = STALL_MEM;
        end else begin
          w_stall     = STALL_ALL;
          w_load_pc   = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
    // Outputs are quiet while reset is held.
    if (rst) begin
      w_stall = STALL_NONE;
      w_flush = 1'b0;
    end
  end

  // Watchdog counter: counts consecutive PC-stalled cycles, saturating.
  always_comb begin
    w_stall_cnt_nxt = '0;
    if (w_stall[0]) begin
      w_stall_cnt_nxt = (r_stall_cnt == CNT_MAX) ? CNT_MAX : r_stall_cnt + 1'b1;
    end
  end

  // State, latched target, redirect address and watchdog registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state     <= ST_RUN;
      r_target    <= '0;
      r_new_pc    <= '0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      if (w_load_target) r_target <= w_excp_target;
      // new_pc only changes on entry to FLUSH, so it holds otherwise.
      if (w_load_pc)     r_new_pc <= w_pc_src;
      if (w_flush)                          r_timeout <= 1'b0;
      else if (w_stall_cnt_nxt == CNT_MAX)  r_timeout <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_stall_cycles;
  logic [31:0] r_perf_flush_count;

  // Free-running performance counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cycles <= '0;
      r_perf_flush_count  <= '0;
    end else begin
      if (w_stall[0]) r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      if (w_flush)    r_perf_flush_count  <= r_perf_flush_count + 32'd1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall_cycles;
  assign o_perf_flush_count  = r_perf_flush_count;
`endif

  assign o_stall         = w_stall;
  assign o_flush         = w_flush;
  assign o_new_pc        = r_new_pc;
  assign o_stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with hand-computed expectations for pipe_ctrl
// (MAX_STALL=4). A driver pushes each cycle's expected outputs into a queue;
// a monitor on the falling edge pops and compares.
module tb_pipe_ctrl;

  typedef struct {
    logic        rst, id, ex, mem, ev, eret;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
  } vec_t;

  typedef struct {
    int          idx;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stallreq_id, i_stallreq_ex, i_stallreq_mem;
  logic        i_excp_valid, i_excp_eret;
  logic [31:0] i_epc_in;
  logic [5:0]  o_stall;
  logic        o_flush;
  logic [31:0] o_new_pc;
  logic        o_stall_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] o_perf_stall_cycles;
  logic [31:0] o_perf_flush_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs[$];
  exp_t exp_q[$];

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0040), .MAX_STALL(4), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_stallreq_id   (i_stallreq_id),
    .i_stallreq_ex   (i_stallreq_ex),
    .i_stallreq_mem  (i_stallreq_mem),
    .i_excp_valid    (i_excp_valid),
    .i_excp_eret     (i_excp_eret),
    .i_epc_in        (i_epc_in),
    .o_stall         (o_stall),
    .o_flush         (o_flush),
    .o_new_pc        (o_new_pc),
`ifdef PIPE_PERF_CNT_EN
    .o_perf_stall_cycles (o_perf_stall_cycles),
    .o_perf_flush_count  (o_perf_flush_count),
`endif
    .o_stall_timeout (o_stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic id, input logic ex, input logic mem,
                             input logic ev, input logic eret, input logic [31:0] epc,
                             input logic [5:0] st, input logic fl, input logic [31:0] pc,
                             input logic to);
    vec_t t;
    t.rst = r; t.id = id; t.ex = ex; t.mem = mem; t.ev = ev; t.eret = eret; t.epc = epc;
    t.stall = st; t.flush = fl; t.pc = pc; t.to = to;
    return t;
  endfunction

  task automatic drive(input logic r, input logic id, input logic ex, input logic mem,
                       input logic ev, input logic eret, input logic [31:0] epc);
    rst = r; i_stallreq_id = id; i_stallreq_ex = ex; i_stallreq_mem = mem;
    i_excp_valid = ev; i_excp_eret = eret; i_epc_in = epc;
  endtask

  // Monitor: compare the DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("v%0d stall", e.idx), 32'(o_stall), 32'(e.stall));
      check($sformatf("v%0d flush", e.idx), 32'(o_flush), 32'(e.flush));
      check($sformatf("v%0d new_pc", e.idx), o_new_pc, e.pc);
      check($sformatf("v%0d timeout", e.idx), 32'(o_stall_timeout), 32'(e.to));
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: simulation still running, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    //              rst id ex mm ev er epc            stall  fl pc             to
    // Reset held two cycles with mem stall and exception asserted.
    vecs.push_back(v(1, 0, 0, 1, 1, 0, 32'h0,         6'h00, 0, 32'h0,         0));
    vecs.push_back(v(1, 0, 0, 1, 1, 0, 32'h0,         6'h00, 0, 32'h0,         0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h0,         0));
    // Stall priority.
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,         6'h07, 0, 32'h0,         0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h0,         0));
    vecs.push_back(v(0, 1, 1, 1, 0, 0, 32'h0,         6'h1F, 0, 32'h0,         0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h0,         0));
    // Exception entry to the vector.
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,         6'h3F, 0, 32'h0,         0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 1, 32'h40,        0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h40,        0));
    // ERET during a 3-cycle bus wait; second exception in PEND ignored.
    // Four consecutive PC stalls (1F,1F,1F,3F) reach MAX_STALL; flush clears it.
    vecs.push_back(v(0, 0, 0, 1, 1, 1, 32'h8000_1234, 6'h1F, 0, 32'h40,        0));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 32'h0,         6'h1F, 0, 32'h40,        0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h0,         6'h1F, 0, 32'h40,        0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h3F, 0, 32'h40,        0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 1, 32'h8000_1234, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h8000_1234, 0));
    // Watchdog: EX stall for 6 cycles, flag rises after the 4th and sticks.
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h8000_1234, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h8000_1234, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h8000_1234, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h8000_1234, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h8000_1234, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 0, 32'h0,         6'h0F, 0, 32'h8000_1234, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h8000_1234, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h8000_1234, 1));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h0,         6'h3F, 0, 32'h8000_1234, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 1, 32'h40,        1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h40,        0));
    // ERET without excp_valid is ignored.
    vecs.push_back(v(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 6'h00, 0, 32'h40,        0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h40,        0));
    // Exception beats simultaneous ID/EX requests; FLUSH ignores requests.
    vecs.push_back(v(0, 1, 1, 0, 1, 1, 32'h1234_5678, 6'h3F, 0, 32'h40,        0));
    vecs.push_back(v(0, 1, 1, 0, 0, 0, 32'h0,         6'h00, 1, 32'h1234_5678, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 32'h0,         6'h07, 0, 32'h1234_5678, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h1234_5678, 0));
    // Reset while an exception is pending discards it.
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 32'h0,         6'h1F, 0, 32'h1234_5678, 0));
    vecs.push_back(v(1, 0, 0, 1, 0, 0, 32'h0,         6'h00, 0, 32'h1234_5678, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h0,         0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 32'h0,         6'h00, 0, 32'h0,         0));

    // Unchecked initial reset cycle brings the state out of X.
    drive(1, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk);

    // Driver: apply each vector just after the edge and queue its expectation.
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      #1;
      drive(vecs[i].rst, vecs[i].id, vecs[i].ex, vecs[i].mem,
            vecs[i].ev, vecs[i].eret, vecs[i].epc);
      e.idx = i; e.stall = vecs[i].stall; e.flush = vecs[i].flush;
      e.pc = vecs[i].pc; e.to = vecs[i].to;
      exp_q.push_back(e);
      @(posedge clk);
    end
    #1;
    drive(0, 0, 0, 0, 0, 0, 32'h0);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

`ifdef PIPE_PERF_CNT_EN
    // 5 request-stalled cycles plus 2 exceptions (2 acceptance cycles at 3F).
    @(posedge clk); #1; drive(1, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 0, 32'h0);
    repeat (5) @(posedge clk);
    #1; drive(0, 0, 0, 0, 1, 0, 32'h0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1; drive(0, 0, 0, 0, 1, 1, 32'h0000_0100);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("perf_stall_cycles", o_perf_stall_cycles, 32'd7);
    check("perf_flush_count", o_perf_flush_count, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the MIPS32 core.
- Merges stall requests from ID, EX and MEM into the 6-bit stall vector consumed by the PC register and the stage registers.
- Sequences exception entry and ERET: it drives flush and new_pc into the PC register.
- Holds a pending exception while a MEM-stage bus stall is active.
- Runs a stall watchdog.

Parameters:
EXC_VECTOR, 32'h00000040, exception handler entry address driven on new_pc for exceptions.
MAX_STALL, 16, consecutive stalled cycles (stall[0]=1) that raise stall_timeout; valid range 1..65535.
CNT_W, 16, width of the consecutive-stall counter.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stallreq_id  in  1  ID-stage stall request (load-use hazard).
stallreq_ex  in  1  EX-stage stall request (multi-cycle mul/div).
stallreq_mem  in  1  MEM-stage stall request (data bus not ready).
excp_valid  in  1  MEM stage reports an exception this cycle.
excp_eret  in  1  MEM stage executes ERET; only meaningful with excp_valid=1.
epc_in  in  32  CP0 EPC value, used for ERET.
stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = hold.
flush  out  1  one-cycle pulse: squash all stage registers and load new_pc.
new_pc  out  32  redirect address, valid while flush=1.
stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: state=RUN, stall=6'b000000, flush=0, new_pc=0, stall_timeout=0, counters=0. Reset mid-sequence discards any pending or latched exception.
- FSM states: RUN, PEND, FLUSH.
- Stall vector in RUN (combinational, priority MEM > EX > ID):
  - stallreq_mem → 6'b011111
  - else stallreq_ex → 6'b001111
  - else stallreq_id → 6'b000111
  - else 6'b000000
- Exception acceptance in RUN:
  - excp_valid=1 and stallreq_mem=0: latch target in the same cycle. Target is epc_in if excp_eret=1, else EXC_VECTOR. Drive stall=6'b111111 for that cycle; next state FLUSH.
  - excp_valid=1 and stallreq_mem=1: latch target and excp_eret; stall=6'b011111; next state PEND.
- PEND:
  - stall=6'b011111 while stallreq_mem=1. New excp_valid inputs are ignored; the first exception wins.
  - When stallreq_mem deasserts: stall=6'b111111 for that cycle, next state FLUSH.
- FLUSH (exactly one cycle):
  - flush=1, new_pc=latched target, stall=6'b000000; all stall requests and excp_valid are ignored.
  - Next state RUN.
- Latency:
  - Accepted exception → flush in the following cycle.
  - The PC loads new_pc on the same edge that ends the FLUSH cycle.
- new_pc holds its last value outside FLUSH. Only flush qualifies it.
- Watchdog:
  - Counter increments each cycle stall[0]=1 and clears on any cycle stall[0]=0. It saturates at MAX_STALL and never wraps.
  - stall_timeout sets when the counter reaches MAX_STALL and stays set until rst or a flush cycle.
- Simultaneous excp_valid and stallreq_ex/id in RUN: the exception wins; stall=6'b111111 that cycle.
- excp_eret=1 with excp_valid=0 is ignored.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0]. Both reset to 0 and wrap at 2^32.
  - perf_stall_cycles increments every cycle stall[0]=1.
  - perf_flush_count increments every FLUSH cycle.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
1. Reset: assert rst 2 cycles with stallreq_mem=1 and excp_valid=1 → stall=0, flush=0, new_pc=0, stall_timeout=0, state RUN after release.
2. Stall priority: stallreq_id=1 → stall=6'h07; add stallreq_ex → 6'h0F; add stallreq_mem → 6'h1F; drop all → 6'h00 in the same cycle.
3. Exception entry: excp_valid=1, excp_eret=0 for one cycle → stall=6'h3F that cycle; next cycle flush=1, new_pc=32'h00000040; following cycle flush=0.
4. ERET during bus wait: stallreq_mem=1 for 3 cycles, excp_valid=1 with excp_eret=1 and epc_in=32'h80001234 in the first of them → stall=6'h1F for 3 cycles; a second excp_valid during PEND is ignored. Then stall=6'h3F for one cycle, then flush=1 with new_pc=32'h80001234.
5. Watchdog: MAX_STALL=4, stallreq_ex held 6 cycles → stall_timeout rises on the 4th stalled cycle and stays high after release. A subsequent exception's flush cycle clears it.
6. Perf counters (PIPE_PERF_CNT_EN defined): 5 stalled cycles plus 2 exceptions → perf_stall_cycles=7 and perf_flush_count=2. The count of 7 is 5 request-stalled cycles plus 2 acceptance cycles at 6'h3F.
